// File: rtl/pipe_skid_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pipe_skid_reg_if                                           |
// | Brief   : Handshake bundle for the elastic pipeline-stage register.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pipe_skid_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  // Stage side of the bundle.
  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  // Environment side: upstream producer plus downstream consumer.
  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pipe_skid_reg                                              |
// | Brief   : Two-entry skid-buffered pipeline stage with flush bubbles. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_skid_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
) (
  input  logic            clock,
  input  logic            reset,
  pipe_skid_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

  // Handshake flags come from state only, so in_ready never sees out_ready.
  assign w_in_ready  = (r_state != ST_FULL);
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_ld_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_nxt    = ST_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_ctrl <= bus.in_ctrl;
        r_main_data <= bus.in_data;
      end else if (w_ld_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_ld_skid) begin
        r_skid_ctrl <= bus.in_ctrl;
        r_skid_data <= bus.in_data;
      end
    end
  end

  // Bubbles carry zero control so they never trigger writes or branches.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};
  assign bus.out_data  = r_main_data;
  assign bus.occupancy = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_pipe_skid_reg                                           |
// | Brief   : Directed and scoreboard checks for pipe_skid_reg.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipe_skid_reg;
  localparam int CTRL_W = 8;
  localparam int DATA_W = 128;

  logic clock;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  pipe_skid_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

  pipe_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = '0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #2;
    total_cnt++;
    if ({bus.out_valid, bus.occupancy, bus.in_ready} !== 4'b0001 ||
        bus.out_ctrl !== 8'h00 || bus.out_data !== 128'd0)
      $display("FAIL reset_init got v=%b occ=%0d rdy=%b ctrl=%h data=%h want v=0 occ=0 rdy=1 ctrl=00 data=0",
               bus.out_valid, bus.occupancy, bus.in_ready, bus.out_ctrl, bus.out_data);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_ctrl  = 8'(i);
      bus.in_data  = 128'(i);
      step();
      total_cnt++;
      if (bus.out_data !== 128'(i) || bus.out_ctrl !== 8'(i) ||
          {bus.out_valid, bus.occupancy, bus.in_ready} !== 4'b1011)
        $display("FAIL stream[%0d] got data=%0d ctrl=%h v=%b occ=%0d rdy=%b want data=%0d ctrl=%h v=1 occ=1 rdy=1",
                 i, bus.out_data, bus.out_ctrl, bus.out_valid, bus.occupancy, bus.in_ready, i, i);
      else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    step();
    total_cnt++;
    if ({bus.out_valid, bus.occupancy} !== 3'b000)
      $display("FAIL stream_drain got v=%b occ=%0d want v=0 occ=0", bus.out_valid, bus.occupancy);
    else pass_cnt++;
  endtask

  task automatic test_skid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 8'h0A;
    bus.in_data   = 128'hA;
    step();
    bus.in_ctrl = 8'h0B;
    bus.in_data = 128'hB;
    step();
    total_cnt++;
    if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 128'hA)
      $display("FAIL skid_full got occ=%0d rdy=%b data=%h want occ=2 rdy=0 data=a",
               bus.occupancy, bus.in_ready, bus.out_data);
    else pass_cnt++;
    bus.in_ctrl = 8'h0C;
    bus.in_data = 128'hC;
    step();
    total_cnt++;
    if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 128'hA)
      $display("FAIL skid_stall got occ=%0d rdy=%b data=%h want occ=2 rdy=0 data=a",
               bus.occupancy, bus.in_ready, bus.out_data);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    step();
    total_cnt++;
    if (bus.out_data !== 128'hB || bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1)
      $display("FAIL skid_release_b got data=%h occ=%0d rdy=%b want data=b occ=1 rdy=1",
               bus.out_data, bus.occupancy, bus.in_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.out_data !== 128'hC || bus.out_ctrl !== 8'h0C || bus.out_valid !== 1'b1)
      $display("FAIL skid_release_c got data=%h ctrl=%h v=%b want data=c ctrl=0c v=1",
               bus.out_data, bus.out_ctrl, bus.out_valid);
    else pass_cnt++;
    bus.in_valid = 1'b0;
    step();
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 8'h00 || bus.out_data !== 128'hC)
      $display("FAIL skid_empty got v=%b ctrl=%h data=%h want v=0 ctrl=00 data=c",
               bus.out_valid, bus.out_ctrl, bus.out_data);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 8'hFF;
    bus.in_data   = 128'h1;
    step();
    bus.in_data = 128'h2;
    step();
    total_cnt++;
    if (bus.occupancy !== 2'd2 || bus.out_ctrl !== 8'hFF)
      $display("FAIL flush_pre got occ=%0d ctrl=%h want occ=2 ctrl=ff", bus.occupancy, bus.out_ctrl);
    else pass_cnt++;
    bus.flush   = 1'b1;
    bus.in_ctrl = 8'h5A;
    bus.in_data = 128'hD;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    total_cnt++;
    if ({bus.out_valid, bus.occupancy, bus.in_ready} !== 4'b0001 || bus.out_ctrl !== 8'h00)
      $display("FAIL flush_after got v=%b occ=%0d rdy=%b ctrl=%h want v=0 occ=0 rdy=1 ctrl=00",
               bus.out_valid, bus.occupancy, bus.in_ready, bus.out_ctrl);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (bus.out_valid !== 1'b0 || bus.out_data === 128'hD)
        $display("FAIL flush_no_d[%0d] got v=%b data=%h want v=0 data!=d", i, bus.out_valid, bus.out_data);
      else pass_cnt++;
    end
    // Flush with out_fire in ONE: head consumed, new input dropped.
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 8'h11;
    bus.in_data  = 128'h11;
    step();
    bus.flush   = 1'b1;
    bus.in_data = 128'h22;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.out_data !== 128'h11)
      $display("FAIL flush_one got v=%b occ=%0d data=%h want v=0 occ=0 data=11",
               bus.out_valid, bus.occupancy, bus.out_data);
    else pass_cnt++;
  endtask

  task automatic test_bubble();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 8'h81;
    bus.in_data   = 128'hDEAD_BEEF;
    step();
    bus.in_valid = 1'b0;
    bus.in_ctrl  = 8'h7E;
    bus.in_data  = 128'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 8'h00 || bus.out_data !== 128'hDEAD_BEEF)
        $display("FAIL bubble[%0d] got v=%b ctrl=%h data=%h want v=0 ctrl=00 data=deadbeef",
                 i, bus.out_valid, bus.out_ctrl, bus.out_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 8'hC3;
    bus.in_data   = 128'h77;
    step();
    step();
    total_cnt++;
    if (bus.occupancy !== 2'd2)
      $display("FAIL rst_mid_pre got occ=%0d want occ=2", bus.occupancy);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({bus.out_valid, bus.occupancy, bus.in_ready} !== 4'b0001 ||
        bus.out_ctrl !== 8'h00 || bus.out_data !== 128'd0)
      $display("FAIL rst_mid got v=%b occ=%0d rdy=%b ctrl=%h data=%h want v=0 occ=0 rdy=1 ctrl=00 data=0",
               bus.out_valid, bus.occupancy, bus.in_ready, bus.out_ctrl, bus.out_data);
    else pass_cnt++;
    @(negedge clock);
    reset         = 1'b1;
    bus.in_data   = 128'h99;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.occupancy !== 2'd1 || bus.out_data !== 128'h99)
      $display("FAIL rst_mid_first got occ=%0d data=%h want occ=1 data=99", bus.occupancy, bus.out_data);
    else pass_cnt++;
    step();
  endtask

  task automatic test_random();
    logic [CTRL_W-1:0] q_ctrl[$];
    logic [DATA_W-1:0] q_data[$];
    int   err;
    int   seq;
    logic rdy_a;
    logic m_in_fire;
    logic m_out_fire;
    err = 0;
    seq = 1000;
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid  = ($urandom_range(99) < 60);
      bus.out_ready = ($urandom_range(99) < 60);
      bus.flush     = ($urandom_range(99) < 5);
      bus.in_ctrl   = 8'($urandom);
      bus.in_data   = 128'(seq);
      #1;
      rdy_a = bus.in_ready;
      bus.out_ready = ~bus.out_ready;
      #1;
      if (bus.in_ready !== rdy_a) begin
        err++;
        if (err < 5) $display("FAIL rand_comb_ready[%0d] got %b want %b", c, bus.in_ready, rdy_a);
      end
      bus.out_ready = ~bus.out_ready;
      #1;
      if (bus.out_valid !== (q_data.size() != 0) || bus.in_ready !== (q_data.size() < 2) ||
          bus.occupancy !== 2'(q_data.size()) ||
          (q_data.size() != 0 && (bus.out_data !== q_data[0] || bus.out_ctrl !== q_ctrl[0])) ||
          (q_data.size() == 0 && bus.out_ctrl !== 8'h00)) begin
        err++;
        if (err < 5)
          $display("FAIL rand[%0d] got v=%b occ=%0d data=%0d ctrl=%h want occ=%0d head=%0d",
                   c, bus.out_valid, bus.occupancy, bus.out_data, bus.out_ctrl,
                   q_data.size(), (q_data.size() != 0) ? q_data[0] : 128'd0);
      end
      m_in_fire  = bus.in_valid && (q_data.size() < 2);
      m_out_fire = bus.out_ready && (q_data.size() != 0);
      if (bus.flush) begin
        q_data.delete();
        q_ctrl.delete();
      end else begin
        if (m_out_fire) begin
          void'(q_data.pop_front());
          void'(q_ctrl.pop_front());
        end
        if (m_in_fire) begin
          q_data.push_back(bus.in_data);
          q_ctrl.push_back(bus.in_ctrl);
        end
      end
      if (m_in_fire) seq++;
      step();
    end
    total_cnt++;
    if (err != 0)
      $display("FAIL random_stress got %0d errors want 0", err);
    else pass_cnt++;
    idle_inputs();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_bubble();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
